// File: rtl/neurosync_round_sequencer_if.sv
// Question ROM bus between the round sequencer (master) and the synchronous
// question ROM (slave); read data is valid one cycle after the address.
interface neurosync_round_sequencer_if #(
  parameter int ADDR_W = 5,
  parameter int W      = 60
);
  logic [ADDR_W-1:0] mem_addr;
  logic [W-1:0]      mem_data;

  modport master (output mem_addr, input mem_data);
  modport slave  (input mem_addr, output mem_data);
endinterface

// File: rtl/neurosync_round_sequencer.sv
// NeuroSync round sequencer: walks one question bank from the ROM, times each
// answer, and keeps score/lives until the game is won or lost.
module neurosync_round_sequencer #(
  parameter int N_MODES     = 4,
  parameter int N_PERGUNTAS = 8,
  parameter int VIDAS       = 3,
  parameter int TIMEOUT     = 500_000_000,
  parameter int MEDIDA_W    = 12,
  parameter int EXP_W       = 28,
  localparam int W       = 8 + 2*MEDIDA_W + EXP_W,
  localparam int ADDR_W  = $clog2(N_MODES*N_PERGUNTAS),
  localparam int MODE_W  = (N_MODES > 1) ? $clog2(N_MODES) : 1,
  localparam int SCORE_W = $clog2(N_PERGUNTAS+1),
  localparam int VIDAS_W = $clog2(VIDAS+1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic [MODE_W-1:0]   modo,
  neurosync_round_sequencer_if.master rom,
  input  logic                pronto_resp,
  input  logic                acertou,
  output logic [1:0]          opcode,
  output logic [3:0]          leds,
  output logic [1:0]          pos_inicial,
  output logic [MEDIDA_W-1:0] lim_inf,
  output logic [MEDIDA_W-1:0] lim_sup,
  output logic [EXP_W-1:0]    expected,
  output logic                set_pos,
  output logic                jogando,
  output logic                timeout,
  output logic [SCORE_W-1:0]  score,
  output logic [VIDAS_W-1:0]  vidas,
  output logic                venceu,
  output logic                perdeu,
  output logic [3:0]          db_estado
);
  localparam int IDX_W   = $clog2(N_PERGUNTAS);
  localparam int TIMER_W = $clog2(TIMEOUT);

  typedef enum logic [3:0] {
    OCIOSO    = 4'd0,
    CARREGA   = 4'd1,
    LE        = 4'd2,
    POSICIONA = 4'd3,
    ESPERA    = 4'd4,
    AVALIA    = 4'd5,
    VENCEU    = 4'd6,
    PERDEU    = 4'd7
  } state_t;

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [MODE_W-1:0]   modo_reg, modo_next;
  logic [W-1:0]        word_reg, word_next;
  logic [TIMER_W-1:0]  timer_reg, timer_next;
  logic                hit_reg, hit_next;
  logic [SCORE_W-1:0]  score_reg, score_next;
  logic [VIDAS_W-1:0]  vidas_reg, vidas_next;
  logic                modo_valid;

  // With a power-of-two bank count every modo encoding names a real bank.
  generate
    if (N_MODES == (2**MODE_W)) begin : g_modo_full
      assign modo_valid = 1'b1;
    end else begin : g_modo_range
      assign modo_valid = (modo < MODE_W'(N_MODES));
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= OCIOSO;
      idx_reg   <= '0;
      modo_reg  <= '0;
      word_reg  <= '0;
      timer_reg <= '0;
      hit_reg   <= 1'b0;
      score_reg <= '0;
      vidas_reg <= VIDAS_W'(VIDAS);
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      modo_reg  <= modo_next;
      word_reg  <= word_next;
      timer_reg <= timer_next;
      hit_reg   <= hit_next;
      score_reg <= score_next;
      vidas_reg <= vidas_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    modo_next  = modo_reg;
    word_next  = word_reg;
    timer_next = timer_reg;
    hit_next   = hit_reg;
    score_next = score_reg;
    vidas_next = vidas_reg;
    set_pos    = 1'b0;
    jogando    = 1'b0;
    timeout    = 1'b0;
    case (state_reg)
      OCIOSO, VENCEU, PERDEU: begin
        if (iniciar) begin
          idx_next   = '0;
          score_next = '0;
          vidas_next = VIDAS_W'(VIDAS);
          modo_next  = modo_valid ? modo : '0;
          state_next = CARREGA;
        end
      end
      CARREGA: state_next = LE;
      LE: begin
        word_next  = rom.mem_data;
        state_next = POSICIONA;
      end
      POSICIONA: begin
        set_pos    = 1'b1;
        timer_next = '0;
        state_next = ESPERA;
      end
      ESPERA: begin
        jogando    = 1'b1;
        timer_next = timer_reg + TIMER_W'(1);
        // A verdict arriving on the expiry cycle beats the timeout.
        if (pronto_resp) begin
          hit_next   = acertou;
          state_next = AVALIA;
        end else if (timer_reg == TIMER_W'(TIMEOUT-1)) begin
          timeout    = 1'b1;
          hit_next   = 1'b0;
          state_next = AVALIA;
        end
      end
      AVALIA: begin
        if (hit_reg) begin
          if (score_reg != SCORE_W'(N_PERGUNTAS)) score_next = score_reg + SCORE_W'(1);
        end else if (vidas_reg != '0) begin
          vidas_next = vidas_reg - VIDAS_W'(1);
        end
        if (vidas_next == '0) begin
          state_next = PERDEU;
        end else if (idx_reg == IDX_W'(N_PERGUNTAS-1)) begin
          state_next = VENCEU;
        end else begin
          idx_next   = idx_reg + IDX_W'(1);
          state_next = CARREGA;
        end
      end
      default: state_next = OCIOSO;
    endcase
  end

  assign rom.mem_addr = ADDR_W'(int'(modo_reg) * N_PERGUNTAS + int'(idx_reg));

  assign opcode      = word_reg[W-1 -: 2];
  assign leds        = word_reg[W-3 -: 4];
  assign pos_inicial = word_reg[W-7 -: 2];
  assign lim_inf     = word_reg[W-9 -: MEDIDA_W];
  assign lim_sup     = word_reg[W-9-MEDIDA_W -: MEDIDA_W];
  assign expected    = word_reg[EXP_W-1:0];

  assign score     = score_reg;
  assign vidas     = vidas_reg;
  assign venceu    = (state_reg == VENCEU);
  assign perdeu    = (state_reg == PERDEU);
  assign db_estado = state_reg;
endmodule
